// File: rtl/dct_da_shift_accumulator_if.sv
// Handshake, sample and ROM bus of the DA shift-accumulator.
interface dct_da_shift_accumulator_if #(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned ROM_W = 16,
   parameter int unsigned ACC_W = 34
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  x0;
   logic [IN_W-1:0]  x1;
   logic [IN_W-1:0]  x2;
   logic [IN_W-1:0]  x3;
   logic             rom_cs;
   logic [2:0]       rom_addr;
   logic [ROM_W-1:0] rom_data;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] z;
   logic             busy;

   // Accumulator side.
   modport slave (
      input  in_valid, x0, x1, x2, x3, rom_data, out_ready,
      output in_ready, rom_cs, rom_addr, out_valid, z, busy
   );

   // Sample source / ROM / result sink side.
   modport master (
      output in_valid, x0, x1, x2, x3, rom_data, out_ready,
      input  in_ready, rom_cs, rom_addr, out_valid, z, busy
   );
endinterface

// File: rtl/dct_da_shift_accumulator.sv
// Distributed-arithmetic bit-serial accumulator for one DCT coefficient.
// Walks four samples MSB-first, addresses a zero-latency ROM with each
// bit-slice and shift-accumulates the returned words into an exact result.
module dct_da_shift_accumulator #(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned ROM_W = 16,
   parameter int unsigned ACC_W = 34
) (
   input logic                       clk,
   input logic                       rst,
   dct_da_shift_accumulator_if.slave bus
);
   localparam int unsigned JW = $clog2(IN_W);

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

   state_e                    r_state;
   state_e                    w_state_next;
   logic [IN_W-1:0]           r_x0;
   logic [IN_W-1:0]           r_x1;
   logic [IN_W-1:0]           r_x2;
   logic [IN_W-1:0]           r_x3;
   logic signed [ACC_W-1:0]   r_acc;
   logic [JW-1:0]             r_j;

   logic                      w_accept;
   logic                      w_sign_slice;
   logic                      w_last_slice;
   logic                      w_x0_bit;
   logic [2:0]                w_a;
   logic [2:0]                w_addr;
   logic signed [ACC_W-1:0]   w_rom_sext;
   logic signed [ACC_W-1:0]   w_term;

   assign w_accept     = (r_state == StIdle) && bus.in_valid;
   assign w_sign_slice = (r_j == JW'(IN_W - 1));
   assign w_last_slice = (r_j == '0);
   assign w_x0_bit     = r_x0[r_j];
   assign w_a          = {r_x1[r_j], r_x2[r_j], r_x3[r_j]};
   // Offset-binary DA: x0 bit selects the mirrored half of the ROM, negating the word.
   assign w_addr       = w_x0_bit ? ~w_a : w_a;
   assign w_rom_sext   = {{(ACC_W - ROM_W){bus.rom_data[ROM_W-1]}}, bus.rom_data};
   assign w_term       = w_x0_bit ? -w_rom_sext : w_rom_sext;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (bus.in_valid) w_state_next = StAccum;
         StAccum: if (w_last_slice) w_state_next = StDone;
         StDone:  if (bus.out_ready) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Sample capture, slice counter and shift-accumulate datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_x0  <= '0;
         r_x1  <= '0;
         r_x2  <= '0;
         r_x3  <= '0;
         r_acc <= '0;
         r_j   <= '0;
      end else if (w_accept) begin
         r_x0  <= bus.x0;
         r_x1  <= bus.x1;
         r_x2  <= bus.x2;
         r_x3  <= bus.x3;
         r_acc <= '0;
         r_j   <= JW'(IN_W - 1);
      end else if (r_state == StAccum) begin
         // Sign slice carries weight -2^(IN_W-1); it seeds the accumulator.
         if (w_sign_slice) begin
            r_acc <= -w_term;
         end else begin
            r_acc <= (r_acc <<< 1) + w_term;
         end
         r_j <= r_j - JW'(1);
      end
   end

   // Output decode.
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.rom_cs    = 1'b0;
      bus.rom_addr  = 3'b000;
      bus.z         = '0;
      bus.busy      = 1'b1;
      unique case (r_state)
         StIdle: begin
            bus.in_ready = 1'b1;
            bus.busy     = 1'b0;
         end
         StAccum: begin
            bus.rom_cs   = 1'b1;
            bus.rom_addr = w_addr;
         end
         StDone: begin
            bus.out_valid = 1'b1;
            bus.z         = r_acc;
         end
         default: begin
            bus.busy = 1'b0;
         end
      endcase
   end
endmodule
